fifo_mac_reader: RTL

Downstream consumer of the parallel-read circular FIFO. It pops PAR_READ-element words from the FIFO and forms a dot product of each word against a latched weight vector. Each group of ACC_LEN consecutive words is accumulated into one result, which is emitted over a valid/ready handshake. This is the first arithmetic stage after buffering in the accelerator datapath.

---
 rtl/fifo_mac_reader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fifo_mac_reader.sv
// -----------------------------------------------------------------------------
// fifo_mac_reader
//
// Consumer stage behind the parallel-read circular FIFO. Each pop delivers
// PAR_READ unsigned elements. These are multiplied element-wise by a weight
// vector that is latched at job start, and the products are summed into a dot
// product. Every ACC_LEN consecutive dot products are accumulated into one
// result, which is presented on a valid/ready handshake. A job produces
// num_results results (0 means 256) and then pulses done.
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   clear        synchronous soft reset; beats everything except rstn
//   start        one-cycle job launch pulse, honoured only in IDLE
//   num_results  results per job, latched on start (0 -> 256)
//   weights      PAR_READ weights, weight i = [i*SIZE +: SIZE], latched on start
//   fifo_dout    FIFO head word, element i = [i*SIZE +: SIZE]
//   fifo_valid   FIFO head word is valid
//   fifo_ren     pop request; a pop happens when fifo_ren && fifo_valid
//   res          accumulated result (wraps modulo 2^OUT_W)
//   res_valid    res holds a result awaiting res_ready
//   res_ready    downstream accepts res
//   busy         job in progress (state != IDLE)
//   done         one-cycle pulse after the last result of a job is accepted
// -----------------------------------------------------------------------------
module fifo_mac_reader #(
    parameter int SIZE     = 4,
    parameter int PAR_READ = 4,
    parameter int ACC_LEN  = 3,
    parameter int OUT_W    = 12
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic                     start,
    input  logic [7:0]               num_results,
    input  logic [PAR_READ*SIZE-1:0] weights,
    input  logic [PAR_READ*SIZE-1:0] fifo_dout,
    input  logic                     fifo_valid,
    output logic                     fifo_ren,
    output logic [OUT_W-1:0]         res,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     busy,
    output logic                     done
);

    // One extra bit keeps the counter at least 1 bit wide when ACC_LEN == 1.
    localparam int CNT_W = $clog2(ACC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(ACC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                     state;
    logic [PAR_READ*SIZE-1:0]   w_reg;
    logic [OUT_W-1:0]           acc;
    logic [CNT_W-1:0]           word_cnt;
    logic [8:0]                 rem;      // 9 bits so a job of 256 results fits
    logic [2*SIZE-1:0]          prod;
    logic [OUT_W-1:0]           dp;

    // Pop only while collecting words. This is combinational so that a word
    // can be consumed on every cycle that the FIFO has one.
    assign fifo_ren = (state == RUN) && fifo_valid;
    assign busy     = (state != IDLE);

    // Dot product of the FIFO head word and the latched weights.
    // NOTE: every variable written in always_comb gets a default before any
    // conditional or loop assignment, so that no latch is inferred.
    always_comb begin
        dp   = '0;
        prod = '0;
        for (int i = 0; i < PAR_READ; i++) begin
            prod = fifo_dout[i*SIZE +: SIZE] * w_reg[i*SIZE +: SIZE];
            dp   = dp + OUT_W'(prod);
        end
    end

    // NOTE: all state is updated with non-blocking assignments. Every register
    // then sees the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            w_reg     <= '0;
            acc       <= '0;
            word_cnt  <= '0;
            rem       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else if (clear) begin
            // A pop that the FIFO performs in this cycle is dropped here. The
            // owner of the FIFO clears it at the same time.
            state     <= IDLE;
            acc       <= '0;
            word_cnt  <= '0;
            rem       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_reg    <= weights;
                        rem      <= (num_results == 8'd0) ? 9'd256 : {1'b0, num_results};
                        acc      <= '0;
                        word_cnt <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (fifo_valid) begin
                        if (word_cnt == LAST_WORD) begin
                            res       <= acc + dp;
                            res_valid <= 1'b1;
                            acc       <= '0;
                            word_cnt  <= '0;
                            state     <= OUT;
                        end else begin
                            acc      <= acc + dp;
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        rem       <= rem - 9'd1;
                        if (rem == 9'd1) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
